// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, iterated
// LSB-first over WIDTH cycles, with a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] r_sh_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             ovf_reg;

  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] r_cat;

  // Full-adder cell on the current LSBs; r_cat is the result with the new bit on top.
  always_comb begin
    bit_s    = a_sh_reg[0] ^ b_sh_reg[0] ^ c_reg;
    bit_c    = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & c_reg) | (b_sh_reg[0] & c_reg);
    last_bit = (cnt_reg == LAST);
    r_cat    = {bit_s, r_sh_reg};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      r_sh_reg  <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_sh_reg  <= a;
            b_sh_reg  <= sub ? ~b : b;
            c_reg     <= sub;
            r_sh_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          r_sh_reg <= r_cat[WIDTH-1:1];
          c_reg    <= bit_c;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_bit) begin
            // c_reg is the carry into the MSB at this point.
            sum_reg   <= r_cat;
            carry_reg <= bit_c;
            ovf_reg   <= c_reg ^ bit_c;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign sum       = sum_reg;
  assign carry_out = carry_reg;
  assign overflow  = ovf_reg;

endmodule
